// File: rtl/io_gearbox4.sv
// io_gearbox4: 4:1 TX serializer and 1:4 RX deserializer for an io block.
// Optional feature: define IOGB_LOOPBACK_EN to add the LOOPBACK input.
module io_gearbox4 #(
  parameter logic IDLE_OUT = 1'b0
) (
  input  logic       IOCLK,
  input  logic       RST,
  input  logic [3:0] TXDATA,
  input  logic       TXOE,
  input  logic       TXVALID,
  output logic       TXREADY,
  output logic       OUT,
  output logic       TS,
  input  logic       IN,
  output logic [3:0] RXDATA,
  output logic       RXVALID,
  input  logic       RXSLIP
`ifdef IOGB_LOOPBACK_EN
  ,
  input  logic       LOOPBACK
`endif
);

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_e;

  tx_state_e  tx_state;
  tx_state_e  tx_state_nx;
  logic [1:0] tcnt;
  logic [1:0] tcnt_nx;
  logic [2:0] tsh;
  logic [2:0] tsh_nx;
  logic       out_q;
  logic       out_nx;
  logic       ts_q;
  logic       ts_nx;
  logic       tx_last;
  logic       tx_acc;

  assign tx_last = (tcnt == 2'd3);
  assign TXREADY = (tx_state == TX_IDLE) || tx_last;
  assign tx_acc  = TXVALID && TXREADY;
  assign OUT     = out_q;
  assign TS      = ts_q;

  // TX next state: load on accept, shift LSB first, release after bit 3
  always_comb begin
    tx_state_nx = tx_state;
    tcnt_nx     = tcnt;
    tsh_nx      = tsh;
    out_nx      = out_q;
    ts_nx       = ts_q;
    if (tx_acc) begin
      tx_state_nx = TX_BUSY;
      tcnt_nx     = 2'd0;
      tsh_nx      = TXDATA[3:1];
      out_nx      = TXDATA[0];
      ts_nx       = TXOE;
    end else if (tx_state == TX_BUSY) begin
      if (!tx_last) begin
        tcnt_nx = tcnt + 2'd1;
        tsh_nx  = {1'b0, tsh[2:1]};
        out_nx  = tsh[0];
      end else begin
        tx_state_nx = TX_IDLE;
        out_nx      = IDLE_OUT;
        ts_nx       = 1'b0;
      end
    end
  end

  // TX state register; reset releases the pad immediately
  always_ff @(posedge IOCLK) begin
    if (RST) begin
      tx_state <= TX_IDLE;
      tcnt     <= 2'd0;
      tsh      <= 3'd0;
      out_q    <= IDLE_OUT;
      ts_q     <= 1'b0;
    end else begin
      tx_state <= tx_state_nx;
      tcnt     <= tcnt_nx;
      tsh      <= tsh_nx;
      out_q    <= out_nx;
      ts_q     <= ts_nx;
    end
  end

  logic       rx_bit;
  logic [2:0] rhist;
  logic [2:0] rhist_nx;
  logic [1:0] rcnt;
  logic [1:0] rcnt_nx;
  logic [3:0] rx_word;
  logic [3:0] rxdata_q;
  logic [3:0] rxdata_nx;
  logic       rxvalid_q;
  logic       rxvalid_nx;
  logic       rx_emit;

`ifdef IOGB_LOOPBACK_EN
  assign rx_bit = LOOPBACK ? out_q : IN;
`else
  assign rx_bit = IN;
`endif

  // the word is the incoming bit plus the last three, oldest bit as LSB
  assign rx_word = {rx_bit, rhist};
  assign rx_emit = (rcnt == 2'd3) && !RXSLIP;
  assign RXDATA  = rxdata_q;
  assign RXVALID = rxvalid_q;

  // RX next state: shift every edge, a slip stalls the bit counter
  always_comb begin
    rhist_nx   = rx_word[3:1];
    rcnt_nx    = rcnt;
    rxdata_nx  = rxdata_q;
    rxvalid_nx = 1'b0;
    if (!RXSLIP) begin
      rcnt_nx = rcnt + 2'd1;
    end
    if (rx_emit) begin
      rxdata_nx  = rx_word;
      rxvalid_nx = 1'b1;
    end
  end

  // RX state register
  always_ff @(posedge IOCLK) begin
    if (RST) begin
      rhist     <= 3'd0;
      rcnt      <= 2'd0;
      rxdata_q  <= 4'd0;
      rxvalid_q <= 1'b0;
    end else begin
      rhist     <= rhist_nx;
      rcnt      <= rcnt_nx;
      rxdata_q  <= rxdata_nx;
      rxvalid_q <= rxvalid_nx;
    end
  end

endmodule

// File: tb/tb_io_gearbox4.sv
// tb_io_gearbox4: directed bench with a cycle-indexed behavioural model.
// Define IOGB_LOOPBACK_EN to exercise the loopback path.
module tb_io_gearbox4;

  localparam logic IDLE = 1'b0;

  logic       IOCLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] TXDATA = 4'h0;
  logic       TXOE = 1'b0;
  logic       TXVALID = 1'b0;
  logic       TXREADY;
  logic       OUT;
  logic       TS;
  logic       IN = 1'b0;
  logic [3:0] RXDATA;
  logic       RXVALID;
  logic       RXSLIP = 1'b0;
`ifdef IOGB_LOOPBACK_EN
  logic       LOOPBACK = 1'b0;
`endif

  always #5 IOCLK = ~IOCLK;

  io_gearbox4 #(.IDLE_OUT(IDLE)) dut (
    .IOCLK   (IOCLK),
    .RST     (RST),
    .TXDATA  (TXDATA),
    .TXOE    (TXOE),
    .TXVALID (TXVALID),
    .TXREADY (TXREADY),
    .OUT     (OUT),
    .TS      (TS),
    .IN      (IN),
    .RXDATA  (RXDATA),
    .RXVALID (RXVALID),
    .RXSLIP  (RXSLIP)
`ifdef IOGB_LOOPBACK_EN
    ,
    .LOOPBACK(LOOPBACK)
`endif
  );

  int ntests = 0;
  int nfail = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk4(input string nm, input logic [3:0] act,
                      input logic [3:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // model: per-cycle expected pad values, a bit history, a word counter
  int         cyc = 0;
  logic       m_out [0:2047];
  logic       m_ts  [0:2047];
  int         last_bit = -100;
  bit         hq[$];
  int         nsc = 0;
  logic       m_rxv = 1'b0;
  logic [3:0] m_rxd = 4'h0;

  task automatic model_step();
    logic rb;
    cyc++;
`ifdef IOGB_LOOPBACK_EN
    rb = LOOPBACK ? m_out[cyc-1] : IN;
`else
    rb = IN;
`endif
    if (RST) begin
      for (int k = 0; k < 4; k++) begin
        m_out[cyc+k] = IDLE;
        m_ts[cyc+k]  = 1'b0;
      end
      last_bit = -100;
      hq = {1'b0, 1'b0, 1'b0, 1'b0};
      nsc = 0;
      m_rxv = 1'b0;
      m_rxd = 4'h0;
    end else begin
      if (TXVALID && (last_bit <= cyc - 1)) begin
        for (int n = 0; n < 4; n++) begin
          m_out[cyc+n] = TXDATA[n];
          m_ts[cyc+n]  = TXOE;
        end
        last_bit = cyc + 3;
      end
      hq.push_back(rb);
      if (hq.size() > 4) void'(hq.pop_front());
      m_rxv = 1'b0;
      if (!RXSLIP) begin
        nsc++;
        if (nsc % 4 == 0) begin
          m_rxv = 1'b1;
          m_rxd = {hq[3], hq[2], hq[1], hq[0]};
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2048; k++) begin
      m_out[k] = IDLE;
      m_ts[k]  = 1'b0;
    end
    hq = {1'b0, 1'b0, 1'b0, 1'b0};
    forever begin
      @(posedge IOCLK);
      model_step();
    end
  end

  // compare every cycle, mid-period
  initial begin
    forever begin
      @(negedge IOCLK);
      if (cyc > 0) begin
        chk1("m_out", OUT, m_out[cyc]);
        chk1("m_ts", TS, m_ts[cyc]);
        chk1("m_txready", TXREADY, last_bit <= cyc);
        chk1("m_rxvalid", RXVALID, m_rxv);
        chk4("m_rxdata", RXDATA, m_rxd);
      end
    end
  end

  task automatic tick();
    @(posedge IOCLK);
    #2;
  endtask

  initial begin
    logic [3:0] w;
    logic [7:0] col;
    logic [3:0] p;
    logic       ev;
    int         good;

    // reset with a word offered: must be ignored
    RST = 1'b1;
    TXVALID = 1'b1;
    TXDATA = 4'hF;
    TXOE = 1'b1;
    tick();
    tick();
    TXVALID = 1'b0;
    RST = 1'b0;
    chk1("rst_out", OUT, IDLE);
    chk1("rst_ts", TS, 1'b0);
    chk1("rst_rdy", TXREADY, 1'b1);
    chk1("rst_rxv", RXVALID, 1'b0);
    chk4("rst_rxd", RXDATA, 4'h0);
    tick();
    chk1("rst_noacc_ts", TS, 1'b0);

    // single word 1011
    w = 4'b1011;
    TXDATA = w;
    TXOE = 1'b1;
    TXVALID = 1'b1;
    tick();
    TXVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk1("w1_out", OUT, w[i]);
      chk1("w1_ts", TS, 1'b1);
      tick();
    end
    chk1("w1_idle_out", OUT, IDLE);
    chk1("w1_idle_ts", TS, 1'b0);

    // A then 5 back to back
    TXDATA = 4'hA;
    TXVALID = 1'b1;
    tick();
    col = 8'h00;
    for (int i = 0; i < 8; i++) begin
      col = {col[6:0], OUT};
      chk1("b2b_ts", TS, 1'b1);
      chk1("b2b_rdy", TXREADY, (i % 4) == 3);
      if (i == 3) TXDATA = 4'h5;
      tick();
      if (i == 3) TXVALID = 1'b0;
    end
    chk8("b2b_bits", col, 8'b01011010);
    chk1("b2b_end_ts", TS, 1'b0);

    // F with output enable off
    TXDATA = 4'hF;
    TXOE = 1'b0;
    TXVALID = 1'b1;
    tick();
    TXVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk1("oe0_out", OUT, 1'b1);
      chk1("oe0_ts", TS, 1'b0);
      tick();
    end

    // reset mid-word of 9, then a fresh 6
    TXDATA = 4'h9;
    TXOE = 1'b1;
    TXVALID = 1'b1;
    tick();
    TXVALID = 1'b0;
    chk1("abort_b0", OUT, 1'b1);
    tick();
    chk1("abort_b1", OUT, 1'b0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk1("abort_ts", TS, 1'b0);
    chk1("abort_out", OUT, IDLE);
    chk1("abort_rdy", TXREADY, 1'b1);
    TXDATA = 4'h6;
    TXVALID = 1'b1;
    tick();
    TXVALID = 1'b0;
    chk1("fresh_b0", OUT, 1'b0);
    chk1("fresh_ts", TS, 1'b1);
    tick();
    chk1("fresh_b1", OUT, 1'b1);
    tick();
    tick();
    tick();

    // RX: pattern 0,1,1,0 with one slip at edge 13
    RST = 1'b1;
    tick();
    RST = 1'b0;
    p = 4'b0110;
    for (int j = 1; j <= 25; j++) begin
      IN = p[(j-1)%4];
      RXSLIP = (j == 13);
      tick();
      ev = (j == 4) || (j == 8) || (j == 12) ||
           (j == 17) || (j == 21) || (j == 25);
      chk1("rx_strobe", RXVALID, ev);
      if (ev) chk4("rx_word", RXDATA, (j < 13) ? 4'h6 : 4'h3);
    end
    for (int j = 26; j <= 44; j++) begin
      IN = p[(j-1)%4];
      RXSLIP = (j == 30) || (j == 31);
      tick();
    end
    RXSLIP = 1'b0;

    // mixed traffic, model-checked
    for (int i = 0; i < 300; i++) begin
      TXVALID = ($urandom_range(3) != 0);
      TXDATA = 4'($urandom);
      TXOE = 1'($urandom);
      IN = 1'($urandom);
      RXSLIP = ($urandom_range(7) == 0);
      RST = ($urandom_range(63) == 0);
      tick();
    end
    TXVALID = 1'b0;
    RXSLIP = 1'b0;
    RST = 1'b0;
    tick();

`ifdef IOGB_LOOPBACK_EN
    RST = 1'b1;
    tick();
    RST = 1'b0;
    LOOPBACK = 1'b1;
    TXDATA = 4'hC;
    TXOE = 1'b1;
    TXVALID = 1'b1;
    good = 0;
    for (int k = 0; k < 120 && good < 3; k++) begin
      tick();
      RXSLIP = 1'b0;
      if (RXVALID) begin
        if (RXDATA == 4'hC) begin
          good++;
        end else begin
          good = 0;
          RXSLIP = 1'b1;
        end
      end
    end
    chk1("lb_aligned", good == 3, 1'b1);
    TXVALID = 1'b0;
    RXSLIP = 1'b0;
    tick();
    LOOPBACK = 1'b0;
    tick();
`else
    good = 0;
`endif

    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
